// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two DMEM requesters, the arbiter and the DMEM instance.
// The slave modport is the arbiter's view; master is the requesters/DMEM side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6
);
    logic              req0, req1;
    logic              we0, we1;
    logic [31:0]       addr0, addr1;
    logic [31:0]       wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              ack0, ack1;
    logic              err0, err1;
    logic [31:0]       rdata0, rdata1;
    logic              busy;
    logic              DM_ena, DM_R, DM_W;
    logic [ADDR_W-1:0] DM_addr;
    logic [31:0]       DM_wdata;
    logic [31:0]       DM_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, DM_rdata,
        output gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1, busy,
               DM_ena, DM_R, DM_W, DM_addr, DM_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, DM_rdata,
        input  gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1, busy,
               DM_ena, DM_R, DM_W, DM_addr, DM_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared DMEM: IDLE -> ACCESS -> RESP,
// one access per three cycles, illegal byte addresses answered with err and no DMEM access.
module dmem_arbiter #(
    parameter logic [31:0] DM_START = 32'h1001_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic           i_clk_in,
    input  logic           i_reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             r_state;
    logic               r_last, r_port, r_we, r_legal, r_busy;
    logic [1:0]         r_gnt, r_ack, r_err;
    logic [1:0][31:0]   r_rdata;
    logic               r_dm_ena, r_dm_r, r_dm_w;
    logic [ADDR_W-1:0]  r_dm_addr;
    logic [31:0]        r_dm_wdata;

    logic               w_any, w_sel, w_we, w_legal;
    logic [31:0]        w_addr, w_wdata, w_word;

    // Tie goes to the port not served last; a lone request wins outright.
    always_comb begin
        w_any   = bus.req0 | bus.req1;
        w_sel   = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
        w_addr  = w_sel ? bus.addr1  : bus.addr0;
        w_wdata = w_sel ? bus.wdata1 : bus.wdata0;
        w_we    = w_sel ? bus.we1    : bus.we0;
        w_word  = (w_addr - DM_START) >> 2;
        w_legal = (w_addr[1:0] == 2'b00) && (w_addr >= DM_START) &&
                  (w_word[31:ADDR_W] == '0);
    end

    always_ff @(posedge i_clk_in or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_legal    <= 1'b0;
            r_busy     <= 1'b0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_dm_ena   <= 1'b0;
            r_dm_r     <= 1'b0;
            r_dm_w     <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_port        <= w_sel;
                    r_we          <= w_we;
                    r_legal       <= w_legal;
                    r_dm_addr     <= w_word[ADDR_W-1:0];
                    r_dm_wdata    <= w_wdata;
                    r_gnt[w_sel]  <= 1'b1;
                    r_dm_ena      <= w_legal;
                    r_dm_r        <= w_legal & ~w_we;
                    r_dm_w        <= w_legal & w_we;
                    r_busy        <= 1'b1;
                    r_state       <= ACCESS;
                end
                ACCESS: begin
                    r_gnt          <= '0;
                    r_dm_ena       <= 1'b0;
                    r_dm_r         <= 1'b0;
                    r_dm_w         <= 1'b0;
                    r_ack[r_port]  <= 1'b1;
                    r_err[r_port]  <= ~r_legal;
                    r_last         <= r_port;
                    // Legal writes leave the port's read data untouched.
                    if (!r_legal)
                        r_rdata[r_port] <= '0;
                    else if (!r_we)
                        r_rdata[r_port] <= bus.DM_rdata;
                    r_state        <= RESP;
                end
                RESP: begin
                    r_ack   <= '0;
                    r_err   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0     = r_gnt[0];
    assign bus.gnt1     = r_gnt[1];
    assign bus.ack0     = r_ack[0];
    assign bus.ack1     = r_ack[1];
    assign bus.err0     = r_err[0];
    assign bus.err1     = r_err[1];
    assign bus.rdata0   = r_rdata[0];
    assign bus.rdata1   = r_rdata[1];
    assign bus.busy     = r_busy;
    assign bus.DM_ena   = r_dm_ena;
    assign bus.DM_R     = r_dm_r;
    assign bus.DM_W     = r_dm_w;
    assign bus.DM_addr  = r_dm_addr;
    assign bus.DM_wdata = r_dm_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: DMEM behavioural memory plus a reference
// memory/legality model, scenario tasks and randomized single-port traffic.
module tb_dmem_arbiter;
    localparam logic [31:0] START = 32'h1001_0000;
    localparam int          AW    = 6;
    localparam int          DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk = 0;
    int   errs = 0;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();

    dmem_arbiter #(.DM_START(START), .ADDR_W(AW)) dut (
        .i_clk_in (clk),
        .i_reset  (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.DM_ena && bus.DM_W) mem[bus.DM_addr] <= bus.DM_wdata;
    assign bus.DM_rdata = mem[bus.DM_addr];

    function automatic bit m_legal(input logic [31:0] a);
        logic [31:0] off;
        off = a - START;
        return (a % 4 == 0) && (a >= START) && (off / 4 < DEPTH);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - START) / 4);
    endfunction

    task automatic access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output bit er, output int lat,
                          output bit ena_seen, output logic [AW-1:0] gaddr);
        lat = -1; ena_seen = 0; rd = 'x; er = 1'b1; gaddr = 'x;
        if (!p) begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        else    begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.DM_ena) ena_seen = 1;
            if (p ? bus.gnt1 : bus.gnt0) gaddr = bus.DM_addr;
            if (p ? bus.ack1 : bus.ack0) begin
                lat = c;
                rd  = p ? bus.rdata1 : bus.rdata0;
                er  = p ? bus.err1 : bus.err0;
                break;
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd; bit er, en; int lat; logic [AW-1:0] ga;
        logic [31:0] prior;
        chk++;
        if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy,
             bus.DM_ena, bus.DM_R, bus.DM_W} !== '0) begin
            errs++; $display("FAIL reset_ctrl got %b want 0", {bus.gnt0, bus.gnt1, bus.ack0,
                bus.ack1, bus.err0, bus.err1, bus.busy, bus.DM_ena, bus.DM_R, bus.DM_W});
        end
        chk++;
        if ({bus.DM_addr, bus.DM_wdata, bus.rdata0, bus.rdata1} !== '0) begin
            errs++; $display("FAIL reset_data got %h/%h/%h/%h want 0", bus.DM_addr,
                bus.DM_wdata, bus.rdata0, bus.rdata1);
        end
        prior = 32'h1234_5678;
        access(0, 1, 32'h1001_0004, prior, rd, er, lat, en, ga);
        ref_mem[1] = prior;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h1001_0004; bus.wdata0 = 32'hBAD0_BAD0;
        @(negedge clk);
        chk++;
        if (bus.DM_W !== 1'b1) begin errs++; $display("FAIL access_dmw got %b want 1", bus.DM_W); end
        #1 rst = 1; bus.req0 = 0;
        #1;
        chk++;
        if ({bus.DM_W, bus.DM_ena, bus.gnt0, bus.busy} !== 4'b0 || bus.DM_addr !== '0) begin
            errs++; $display("FAIL reset_mid got w=%b e=%b g=%b b=%b a=%h want 0", bus.DM_W,
                bus.DM_ena, bus.gnt0, bus.busy, bus.DM_addr);
        end
        #1 rst = 0;
        @(negedge clk);
        access(0, 0, 32'h1001_0004, 0, rd, er, lat, en, ga);
        chk++;
        if (rd !== ref_mem[1]) begin errs++; $display("FAIL reset_nocommit got %h want %h", rd, ref_mem[1]); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; bit er, en; int lat; logic [AW-1:0] ga;
        access(0, 1, 32'h1001_0008, 32'hDEAD_BEEF, rd, er, lat, en, ga);
        ref_mem[2] = 32'hDEAD_BEEF;
        chk++;
        if (lat !== 2 || ga !== 6'd2 || er !== 1'b0) begin
            errs++; $display("FAIL wr_port0 got lat=%0d addr=%0d err=%b want 2/2/0", lat, ga, er);
        end
        access(0, 0, 32'h1001_0008, 0, rd, er, lat, en, ga);
        chk++;
        if (lat !== 2 || ga !== 6'd2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL rd_port0 got lat=%0d addr=%0d err=%b data=%h want 2/2/0/deadbeef",
                lat, ga, er, rd);
        end
    endtask

    task automatic test_tie();
        int ack_c[$]; bit ack_p[$]; logic [31:0] ack_d[$];
        int gnt_cycles; bit both;
        rst = 1; #2 rst = 0;
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h1001_0014;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h1001_0018;
        gnt_cycles = 0; both = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) gnt_cycles++;
            if (bus.gnt0 && bus.gnt1) both = 1;
            if (bus.ack0) begin ack_c.push_back(c); ack_p.push_back(0); ack_d.push_back(bus.rdata0); end
            if (bus.ack1) begin ack_c.push_back(c); ack_p.push_back(1); ack_d.push_back(bus.rdata1); end
        end
        bus.req0 = 0; bus.req1 = 0;
        @(negedge clk); @(negedge clk);
        chk++;
        if (ack_c.size() != 4) begin
            errs++; $display("FAIL tie_count got %0d acks want 4", ack_c.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk++;
                if (ack_c[i] != 2 + 3 * i || ack_p[i] !== bit'(i % 2) ||
                    ack_d[i] !== ref_mem[(i % 2) ? 6 : 5]) begin
                    errs++; $display("FAIL tie_ack%0d got cyc=%0d port=%0d data=%h want %0d/%0d/%h",
                        i, ack_c[i], ack_p[i], ack_d[i], 2 + 3 * i, i % 2, ref_mem[(i % 2) ? 6 : 5]);
                end
            end
        end
        chk++;
        if (gnt_cycles != 4 || both || bus.busy !== 1'b0) begin
            errs++; $display("FAIL tie_gnt got %0d gnt cycles both=%b busy=%b want 4/0/0",
                gnt_cycles, both, bus.busy);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        logic [31:0] rd; bit er, en; int lat; logic [AW-1:0] ga;
        bad[0] = 32'h1000_FFFC; bad[1] = 32'h1001_0002; bad[2] = 32'h1001_0100;
        for (int i = 0; i < 3; i++) begin
            access(1, 0, bad[i], 0, rd, er, lat, en, ga);
            chk++;
            if (lat !== 2 || er !== 1'b1 || rd !== 32'h0 || en !== 1'b0) begin
                errs++; $display("FAIL illegal_%h got lat=%0d err=%b data=%h ena=%b want 2/1/0/0",
                    bad[i], lat, er, rd, en);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd; bit er, en; int lat; logic [AW-1:0] ga;
        access(0, 0, 32'h1001_00FC, 0, rd, er, lat, en, ga);
        chk++;
        if (ga !== 6'd63 || er !== 1'b0 || rd !== ref_mem[63] || lat !== 2) begin
            errs++; $display("FAIL boundary got addr=%0d err=%b data=%h lat=%0d want 63/0/%h/2",
                ga, er, rd, lat, ref_mem[63]);
        end
    endtask

    task automatic test_change_after_latch();
        logic [AW-1:0] ga;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h1001_0010;
        @(negedge clk);
        ga = bus.DM_addr;
        bus.addr1 = 32'h1001_0020; bus.we1 = 1; bus.wdata1 = 32'hFFFF_0000;
        chk++;
        if (bus.gnt1 !== 1'b1 || ga !== 6'd4) begin
            errs++; $display("FAIL latch_addr got gnt=%b addr=%0d want 1/4", bus.gnt1, ga);
        end
        @(negedge clk);
        chk++;
        if (bus.ack1 !== 1'b1 || bus.rdata1 !== ref_mem[4]) begin
            errs++; $display("FAIL latch_data got ack=%b data=%h want 1/%h", bus.ack1, bus.rdata1, ref_mem[4]);
        end
        bus.req1 = 0; bus.we1 = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp_rd; bit er, en, p, we, lg; int lat, k; logic [AW-1:0] ga;
        for (int n = 0; n < 48; n++) begin
            p = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); d = $urandom;
            k = $urandom_range(0, 9);
            if (k < 7)       a = START + 4 * $urandom_range(0, DEPTH - 1);
            else if (k == 7) a = START - 4 * $urandom_range(1, 16);
            else if (k == 8) a = START + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            else             a = START + 4 * DEPTH + 4 * $urandom_range(0, 1000);
            lg = m_legal(a);
            exp_rd = lg ? ref_mem[m_idx(a)] : 32'h0;
            access(p, we, a, d, rd, er, lat, en, ga);
            if (lg && we) ref_mem[m_idx(a)] = d;
            chk++;
            if (lat !== 2 || er !== !lg || en !== lg || (!we && rd !== exp_rd) || (!lg && rd !== 0)) begin
                errs++; $display("FAIL rand%0d p%0d we=%b a=%h got lat=%0d err=%b ena=%b data=%h want 2/%b/%b/%h",
                    n, p, we, a, lat, er, en, rd, !lg, lg, exp_rd);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk++;
            if (mem[i] !== ref_mem[i]) begin
                errs++; $display("FAIL mem_final[%0d] got %h want %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_tie();
        test_illegal();
        test_boundary();
        test_change_after_latch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared data memory (DMEM) of the single-cycle CPU system. It lets the CPU data port (port 0) and a second master (port 1, debug/loader/DMA) share one DMEM. It translates byte addresses to DMEM word indices, rejects illegal addresses without touching memory, and returns read data and a completion pulse to the winning requester. It sits between the masters and the DMEM instance, and drives DMEM's CS, DM_R, DM_W, addr and data_in.

## Interface
Parameters:
- DM_START, 32'h1001_0000, byte address of DMEM word 0
- ADDR_W, 6, DMEM word-index width (depth = 2^ADDR_W words)

Ports:
- clk_in  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held until matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  byte address
- wdata0 / wdata1  in  32  write data
- gnt0 / gnt1  out  1  high during the ACCESS cycle of that port
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack; 1 = address rejected
- rdata0 / rdata1  out  32  read data; held until that port's next ack
- busy  out  1  state != IDLE
- DM_ena  out  1  to DMEM CS
- DM_R  out  1  to DMEM DM_R
- DM_W  out  1  to DMEM DM_W
- DM_addr  out  ADDR_W  to DMEM addr
- DM_wdata  out  32  to DMEM data_in
- DM_rdata  in  32  from DMEM data_out (combinational read)

## Operation
FSM states are IDLE, ACCESS and RESP.

IDLE:
- If neither request is active, stay in IDLE.
- If exactly one reqN is high, select that port.
- If both are high, select the port not served last. The `last` pointer resets to 1, so port 0 wins the first tie.
- On selection, latch into internal registers: port id, we, wdata, word index = (addrN - DM_START) >> 2, and legal. Go to ACCESS.
- legal = addrN[1:0] == 0 AND addrN >= DM_START AND (addrN - DM_START) >> 2 < 2^ADDR_W.

ACCESS (one cycle):
- gntN = 1.
- If legal: DM_ena = 1, DM_R = !we, DM_W = we, DM_addr = latched index, DM_wdata = latched wdata. A write commits at the closing edge. For a read, DM_rdata is captured into rdataN at the closing edge.
- If illegal: all DMEM controls are 0, and rdataN is loaded with 0.
- Set errN = !legal and `last` = N. Go to RESP.

RESP (one cycle):
- ackN = 1 and errN is valid.
- Go to IDLE. The requester must drop reqN at or before the edge ending RESP, otherwise it is re-arbitrated as a new request.

Rules:
- Outside ACCESS, DM_ena, DM_R and DM_W are 0. DM_addr and DM_wdata hold their latched values; they are don't-care to DMEM.
- Request inputs are sampled only in IDLE. Changes to weN, addrN or wdataN after latching have no effect on the in-flight access.
- A request dropped before it is sampled in IDLE is never served.
- The non-selected port sees no gnt and no ack. It waits at most one full access (3 cycles) beyond the current one.
- Subtraction is 32-bit unsigned. Addresses below DM_START are caught by the >= compare, not by wrap-around.

## Timing
- Reset, applied asynchronously at any time including mid-ACCESS:
  - State goes to IDLE and `last` to 1.
  - gnt, ack, err, busy, DM_ena, DM_R and DM_W are all 0.
  - DM_addr, DM_wdata, rdata0 and rdata1 are all 0.
  - A write in progress must not commit: DM_W drops with reset, before any later edge.
- Latency: a request sampled at edge k is in ACCESS during cycle k..k+1 and asserts ack during cycle k+1..k+2. Request to ack is 2 cycles.
- Throughput: one access per 3 cycles. Alternating service when both ports request continuously.
- rdataN changes only at the edge entering that port's RESP.

## Test plan
- Reset: assert reset mid-ACCESS of a write (we0 = 1, addr0 = 32'h1001_0004) -> DM_W falls immediately, state IDLE, all outputs 0, and a later read of that word returns its prior value.
- Single write then read, port 0: write 32'hDEAD_BEEF to 32'h1001_0008, then read it back -> DM_addr = 2, ack0 two cycles after each req, rdata0 = 32'hDEAD_BEEF, err0 = 0.
- Simultaneous requests from reset, both held high: port 0 acked first, then port 1, then port 0. Each gnt lasts one cycle, and there are 3 cycles between acks.
- Illegal addresses 32'h1000_FFFC, 32'h1001_0002 and 32'h1001_0100 (ADDR_W = 6) -> ack with err = 1, rdata = 0, DM_ena never asserted.
- Boundary: read 32'h1001_00FC -> DM_addr = 63, err = 0.
- Request changed after latch: port 1 switches addr1 from 32'h1001_0010 to 32'h1001_0020 during ACCESS -> DM_addr = 4, and rdata1 is the word at index 4.
